video_ctrl_top: RTL and testbench
=================================

# video_ctrl_top

Top level of the FPGA video controller for the DE10-Nano board. It takes the 50 MHz board clock and the push-button reset, drives board LEDs, and generates a VGA-style video stream on a video interface. The stream carries HS, VS and BLANK timing plus an internally generated test pattern (grid). The hardware-support interface is the attachment point for the board's memory/HPS bridge; this block exposes it but issues no traffic on it.

## Interface

Parameters:
- HDISP, 800: active pixels per line
- VDISP, 480: active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40: horizontal front porch, sync and back porch, in pixels
- VFP / VPULSE / VBP, 13 / 3 / 29: vertical front porch, sync and back porch, in lines
- LED_DIV, 25_000_000: clock cycles per LED[0] toggle (0.5 s at 50 MHz)

Ports:
- FPGA_CLK1_50, in, 1: single clock for the whole block; also used as the pixel clock
- KEY, in, 2: KEY[0] is the reset, asynchronous and active-low; KEY[1] is unused
- LED, out, 8: status LEDs
- SW, in, 4: board switches
- video_ifm, video_if master port:
  - CLK: pixel clock, equal to FPGA_CLK1_50
  - HS: horizontal sync, active-low
  - VS: vertical sync, active-low
  - BLANK: high in the active area, low in blanking
  - RGB[23:0]: pixel colour
- hws_ifm, hws_if master port: hardware-support bus; kept idle (no request issued)

## Operation

Reset:
- KEY[0] low asynchronously asserts the internal reset rst.
- Release is synchronised through a 2-flop chain clocked by FPGA_CLK1_50.
- rst resets all counters and all output registers.

LEDs:
- LED[0]: toggles every LED_DIV cycles; 0 in reset.
- LED[1]: toggles at each frame start (counters wrap to 0,0); 0 in reset.
- LED[3:2]: constant 0.
- LED[7:4]: registered copy of SW; 0 in reset.

Timing counters:
- HTOT = HFP + HPULSE + HBP + HDISP.
- VTOT = VFP + VPULSE + VBP + VDISP.
- cx counts 0..HTOT-1. It wraps to 0 at HTOT-1, and cy increments on that wrap.
- cy counts 0..VTOT-1 and wraps to 0.
- Each line is ordered: front porch, sync, back porch, active. Frames follow the same order vertically.

Output generation (combinational terms registered once):
- HS = 0 when HFP ≤ cx < HFP+HPULSE, else 1.
- VS = 0 when VFP ≤ cy < VFP+VPULSE, else 1.
- BLANK = 1 when cx ≥ HFP+HPULSE+HBP and cy ≥ VFP+VPULSE+VBP, else 0.
- Active coordinates are x = cx − (HFP+HPULSE+HBP) and y = cy − (VFP+VPULSE+VBP).
- RGB = 24'hFFFFFF when BLANK is true and (x[3:0]==0 or y[3:0]==0), giving a white grid with 16-pixel pitch. Otherwise RGB = 0.
- RGB is 0 whenever BLANK is 0.

hws_ifm:
- All master request signals are held inactive (no read or write strobe) at all times.

Reset values of outputs:
- HS = 1, VS = 1, BLANK = 0, RGB = 0.
- LED = 8'h00.

## Timing

- Pipeline latency from counter state to video outputs: 1 cycle. HS, VS, BLANK and RGB are mutually aligned.
- Counter widths: cx holds HTOT−1 and cy holds VTOT−1, sized with $clog2. There is no overflow at wrap.
- After rst release, the counters start at (0,0).
  - The first HS falling edge comes HFP+1 cycles later.
  - The first BLANK rising edge comes HFP+HPULSE+HBP+1 cycles after the first cycle of line VFP+VPULSE+VBP.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously). After release, the stream restarts at (0,0).
- With HDISP=160 and VDISP=90: HTOT=288, VTOT=135, so one frame is 38 880 cycles (777.6 µs).

## Test plan

- Reset: KEY[0] = 0 for 128 ns, then 1 → during reset HS = VS = 1, BLANK = 0, RGB = 0, LED = 0. The first HS low comes 41 cycles after the second synchroniser edge.
- Line timing (HDISP=160, VDISP=90): HS period is 288 cycles with low width 48. Each active line has exactly 160 consecutive BLANK = 1 cycles.
- Frame timing: VS period is 135 lines with low width 3 lines. Each frame has exactly 90 lines containing BLANK = 1.
- Pattern: white pixels at x ∈ {0,16,…,144} on every active line, and on the whole of lines y ∈ {0,16,…,80}. All other pixels are black, and RGB = 0 in blanking.
- LEDs: SW = 4'b1010 → LED[7:4] = 4'b1010 one cycle later. LED[1] toggles once per frame (every 777.6 µs). With LED_DIV=100, LED[0] toggles every 2 µs.
- Mid-frame reset: pulse KEY[0] low at cy=50 → outputs return to reset values at once, then the stream restarts at (0,0). Over 4 ms the screen model receives complete 160×90 frames with no timing error reported.

Source files
------------

// File: rtl/video_ctrl_top_if.sv
// Board-level interfaces of the video controller: the VGA-style video stream
// and the hardware-support (memory/HPS bridge) bus.
interface video_if;
    logic        CLK;
    logic        HS;
    logic        VS;
    logic        BLANK;
    logic [23:0] RGB;

    modport master (output CLK, output HS, output VS, output BLANK, output RGB);
    modport slave  (input  CLK, input  HS, input  VS, input  BLANK, input  RGB);
endinterface

interface hws_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, output read, output write, output writedata, output byteenable,
        input  readdata, input readdatavalid, input waitrequest
    );
    modport slave (
        input  address, input read, input write, input writedata, input byteenable,
        output readdata, output readdatavalid, output waitrequest
    );
endinterface

// File: rtl/video_ctrl_top.sv
// DE10-Nano video controller top: reset synchroniser, VGA timing counters,
// registered HS/VS/BLANK with a 16-pixel white grid pattern, and status LEDs.
module video_ctrl_top #(
    parameter int HDISP   = 800,
    parameter int VDISP   = 480,
    parameter int HFP     = 40,
    parameter int HPULSE  = 48,
    parameter int HBP     = 40,
    parameter int VFP     = 13,
    parameter int VPULSE  = 3,
    parameter int VBP     = 29,
    parameter int LED_DIV = 25_000_000
) (
    input  logic       FPGA_CLK1_50,
    input  logic [1:0] KEY,
    output logic [7:0] LED,
    input  logic [3:0] SW,
    video_if.master    video_ifm,
    hws_if.master      hws_ifm
);
    localparam int HTOT   = HFP + HPULSE + HBP + HDISP;
    localparam int VTOT   = VFP + VPULSE + VBP + VDISP;
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;
    localparam int CXW    = $clog2(HTOT);
    localparam int CYW    = $clog2(VTOT);
    localparam int LDW    = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

    logic clk;
    assign clk = FPGA_CLK1_50;

    // Reset asserts asynchronously from KEY[0]; release is aligned to clk.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge clk or negedge KEY[0]) begin
        if (!KEY[0]) rst_sync_q <= 2'b00;
        else         rst_sync_q <= rst_sync_d;
    end

    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    logic           line_end, frame_end;

    always_comb begin
        cx_d      = cx_q + CXW'(1);
        cy_d      = cy_q;
        line_end  = (cx_q == CXW'(HTOT - 1));
        frame_end = line_end && (cy_q == CYW'(VTOT - 1));
        if (line_end) begin
            cx_d = '0;
            cy_d = frame_end ? '0 : cy_q + CYW'(1);
        end
    end

    // Only the low nibble of the active coordinates matters for the grid.
    logic [3:0]  x_lo, y_lo;
    logic        hs_d, vs_d, blank_d;
    logic [23:0] rgb_d;
    logic        hs_q, vs_q, blank_q;
    logic [23:0] rgb_q;

    always_comb begin
        x_lo    = cx_q[3:0] - 4'(HSTART);
        y_lo    = cy_q[3:0] - 4'(VSTART);
        hs_d    = !((cx_q >= CXW'(HFP)) && (cx_q < CXW'(HFP + HPULSE)));
        vs_d    = !((cy_q >= CYW'(VFP)) && (cy_q < CYW'(VFP + VPULSE)));
        blank_d = (cx_q >= CXW'(HSTART)) && (cy_q >= CYW'(VSTART));
        rgb_d   = 24'h000000;
        if (blank_d && ((x_lo == 4'd0) || (y_lo == 4'd0))) rgb_d = 24'hFFFFFF;
    end

    logic [LDW-1:0] led_cnt_q, led_cnt_d;
    logic           led0_q, led0_d;
    logic           led1_q, led1_d;
    logic [3:0]     sw_q, sw_d;

    always_comb begin
        led_cnt_d = led_cnt_q + LDW'(1);
        led0_d    = led0_q;
        if (led_cnt_q == LDW'(LED_DIV - 1)) begin
            led_cnt_d = '0;
            led0_d    = !led0_q;
        end
        led1_d = frame_end ? !led1_q : led1_q;
        sw_d   = SW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q      <= '0;
            cy_q      <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_q   <= 1'b0;
            rgb_q     <= 24'h000000;
            led_cnt_q <= '0;
            led0_q    <= 1'b0;
            led1_q    <= 1'b0;
            sw_q      <= 4'h0;
        end else begin
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_q   <= blank_d;
            rgb_q     <= rgb_d;
            led_cnt_q <= led_cnt_d;
            led0_q    <= led0_d;
            led1_q    <= led1_d;
            sw_q      <= sw_d;
        end
    end

    assign LED = {sw_q, 2'b00, led1_q, led0_q};

    assign video_ifm.CLK   = clk;
    assign video_ifm.HS    = hs_q;
    assign video_ifm.VS    = vs_q;
    assign video_ifm.BLANK = blank_q;
    assign video_ifm.RGB   = rgb_q;

    // The bridge is exposed for later use but never issues a request.
    assign hws_ifm.address    = 32'h0;
    assign hws_ifm.read       = 1'b0;
    assign hws_ifm.write      = 1'b0;
    assign hws_ifm.writedata  = 32'h0;
    assign hws_ifm.byteenable = 4'h0;

    logic unused_inputs;
    assign unused_inputs = ^{KEY[1], hws_ifm.readdata, hws_ifm.readdatavalid,
                             hws_ifm.waitrequest};
endmodule

// File: tb/tb_video_ctrl_top.sv
// Directed bench for video_ctrl_top on a 160x90 screen: reset, LEDs, line and
// frame timing, grid pattern and mid-frame reset recovery.
module tb_video_ctrl_top;
    localparam int HDISP   = 160;
    localparam int VDISP   = 90;
    localparam int HFP     = 40;
    localparam int HPULSE  = 48;
    localparam int HBP     = 40;
    localparam int VFP     = 13;
    localparam int VPULSE  = 3;
    localparam int VBP     = 29;
    localparam int LED_DIV = 100;
    localparam int HTOT    = 288;
    localparam int VTOT    = 135;
    localparam int FRAME   = 38880;
    localparam int HSTART  = 128;
    localparam int VSTART  = 45;

    logic       clk = 1'b0;
    logic [1:0] key;
    logic [7:0] led;
    logic [3:0] sw;

    always #10 clk = ~clk;

    video_if vif ();
    hws_if   hif ();

    video_ctrl_top #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .LED_DIV(LED_DIV)
    ) dut (
        .FPGA_CLK1_50(clk),
        .KEY(key),
        .LED(led),
        .SW(sw),
        .video_ifm(vif),
        .hws_ifm(hif)
    );

    int errors = 0;
    int checks = 0;
    int pos, cyc;
    int pix_bad, first_bad_pos;
    int hs_falls, hs_per_bad, hs_low_bad, last_hs_fall, first_hs_fall;
    int blank_start, blank_run_bad, blank_lines, white_cnt, first_blank;
    int vs_fall1, vs_fall2, vs_low;
    int led1_toggles, led1_pos, led0_first, led0_bad, last_led0;
    logic prev_hs, prev_vs, prev_blank, prev_led0, prev_led1;

    task automatic clear_trackers();
        pix_bad = 0; first_bad_pos = -1;
        hs_falls = 0; hs_per_bad = 0; hs_low_bad = 0; last_hs_fall = -1; first_hs_fall = -1;
        blank_start = -1; blank_run_bad = 0; blank_lines = 0; white_cnt = 0; first_blank = -1;
        vs_fall1 = -1; vs_fall2 = -1; vs_low = -1;
        led1_toggles = 0; led1_pos = -1; led0_first = -1; led0_bad = 0; last_led0 = -1;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_blank = 1'b0; prev_led0 = 1'b0; prev_led1 = 1'b0;
    endtask

    // One pixel clock: outputs seen at the following negedge show counter value pos.
    task automatic step();
        int cx, cy, xo, yo;
        logic ehs, evs, eb;
        logic [23:0] ergb;
        @(posedge clk);
        pos++;
        cyc++;
        @(negedge clk);
        cx   = pos % HTOT;
        cy   = (pos / HTOT) % VTOT;
        xo   = cx - HSTART;
        yo   = cy - VSTART;
        ehs  = !(cx >= HFP && cx < HFP + HPULSE);
        evs  = !(cy >= VFP && cy < VFP + VPULSE);
        eb   = (cx >= HSTART) && (cy >= VSTART);
        ergb = (eb && ((xo % 16 == 0) || (yo % 16 == 0))) ? 24'hFFFFFF : 24'h000000;
        if (vif.HS !== ehs || vif.VS !== evs || vif.BLANK !== eb || vif.RGB !== ergb) begin
            if (pix_bad == 0) first_bad_pos = pos;
            pix_bad++;
        end
        if (prev_hs && !vif.HS) begin
            if (first_hs_fall < 0) first_hs_fall = pos;
            if (last_hs_fall >= 0 && cyc - last_hs_fall != HTOT) hs_per_bad++;
            last_hs_fall = cyc;
            hs_falls++;
        end
        if (!prev_hs && vif.HS && last_hs_fall >= 0 && cyc - last_hs_fall != HPULSE) hs_low_bad++;
        if (!prev_blank && vif.BLANK) begin
            if (first_blank < 0) first_blank = pos;
            if (pos < FRAME) blank_lines++;
            blank_start = cyc;
        end
        if (prev_blank && !vif.BLANK && cyc - blank_start != HDISP) blank_run_bad++;
        if (pos < FRAME && vif.RGB === 24'hFFFFFF) white_cnt++;
        if (prev_vs && !vif.VS) begin
            if (vs_fall1 < 0) vs_fall1 = cyc;
            else if (vs_fall2 < 0) vs_fall2 = cyc;
        end
        if (!prev_vs && vif.VS && vs_low < 0) vs_low = cyc - vs_fall1;
        if (prev_led1 !== led[1]) begin
            led1_toggles++;
            led1_pos = pos;
        end
        if (prev_led0 !== led[0]) begin
            if (led0_first < 0) led0_first = pos;
            if (last_led0 >= 0 && cyc - last_led0 != LED_DIV) led0_bad++;
            last_led0 = cyc;
        end
        prev_hs = vif.HS; prev_vs = vif.VS; prev_blank = vif.BLANK;
        prev_led0 = led[0]; prev_led1 = led[1];
    endtask

    task automatic test_reset();
        key = 2'b10;
        sw  = 4'h0;
        #100;
        checks += 5;
        if (vif.HS !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b expected 1", vif.HS); end
        if (vif.VS !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b expected 1", vif.VS); end
        if (vif.BLANK !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b expected 0", vif.BLANK); end
        if (vif.RGB !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", vif.RGB); end
        if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
        #28;
        key[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        pos = -1;
        cyc = 0;
        clear_trackers();
        repeat (40) step();
        checks++;
        if (vif.HS !== 1'b1) begin errors++; $display("FAIL hs_before_first_low: got %b expected 1", vif.HS); end
        step();
        checks++;
        if (vif.HS !== 1'b0) begin errors++; $display("FAIL first_hs_low_41: got %b expected 0", vif.HS); end
        checks += 2;
        if (hif.read !== 1'b0) begin errors++; $display("FAIL hws_read_idle: got %b expected 0", hif.read); end
        if (hif.write !== 1'b0) begin errors++; $display("FAIL hws_write_idle: got %b expected 0", hif.write); end
    endtask

    task automatic test_leds();
        sw = 4'b1010;
        #1;
        checks++;
        if (led[7:4] !== 4'b0000) begin errors++; $display("FAIL sw_registered: got %b expected 0000", led[7:4]); end
        step();
        checks += 2;
        if (led[7:4] !== 4'b1010) begin errors++; $display("FAIL sw_1010: got %b expected 1010", led[7:4]); end
        if (led[3:2] !== 2'b00) begin errors++; $display("FAIL led_3_2: got %b expected 00", led[3:2]); end
        sw = 4'b0101;
        step();
        checks++;
        if (led[7:4] !== 4'b0101) begin errors++; $display("FAIL sw_0101: got %b expected 0101", led[7:4]); end
    endtask

    task automatic test_frame_timing();
        while (pos < FRAME + 20 * HTOT) step();
        checks += 13;
        if (pix_bad !== 0) begin errors++; $display("FAIL frame_pixels: got %0d bad samples (first at pos %0d) expected 0", pix_bad, first_bad_pos); end
        if (hs_falls !== 155) begin errors++; $display("FAIL hs_fall_count: got %0d expected 155", hs_falls); end
        if (hs_per_bad !== 0) begin errors++; $display("FAIL hs_period_288: got %0d bad periods expected 0", hs_per_bad); end
        if (hs_low_bad !== 0) begin errors++; $display("FAIL hs_low_48: got %0d bad widths expected 0", hs_low_bad); end
        if (blank_run_bad !== 0) begin errors++; $display("FAIL blank_run_160: got %0d bad runs expected 0", blank_run_bad); end
        if (blank_lines !== 90) begin errors++; $display("FAIL blank_lines: got %0d expected 90", blank_lines); end
        if (white_cnt !== 1800) begin errors++; $display("FAIL white_pixels: got %0d expected 1800", white_cnt); end
        if (vs_fall2 - vs_fall1 !== 38880) begin errors++; $display("FAIL vs_period: got %0d expected 38880", vs_fall2 - vs_fall1); end
        if (vs_low !== 864) begin errors++; $display("FAIL vs_low_3_lines: got %0d expected 864", vs_low); end
        if (led1_toggles !== 1) begin errors++; $display("FAIL led1_toggle_count: got %0d expected 1", led1_toggles); end
        if (led1_pos !== 38879) begin errors++; $display("FAIL led1_toggle_pos: got %0d expected 38879", led1_pos); end
        if (led0_first !== 99) begin errors++; $display("FAIL led0_first_toggle: got %0d expected 99", led0_first); end
        if (led0_bad !== 0) begin errors++; $display("FAIL led0_period_100: got %0d bad periods expected 0", led0_bad); end
    endtask

    task automatic test_mid_reset();
        while (pos < FRAME + 50 * HTOT + HSTART) step();
        checks += 3;
        if (vif.BLANK !== 1'b1) begin errors++; $display("FAIL pre_reset_blank: got %b expected 1", vif.BLANK); end
        if (vif.RGB !== 24'hFFFFFF) begin errors++; $display("FAIL pre_reset_rgb: got %h expected ffffff", vif.RGB); end
        if (led[7:4] !== 4'b0101) begin errors++; $display("FAIL pre_reset_led: got %b expected 0101", led[7:4]); end
        key[0] = 1'b0;
        #1;
        checks += 5;
        if (vif.HS !== 1'b1) begin errors++; $display("FAIL mid_reset_hs: got %b expected 1", vif.HS); end
        if (vif.VS !== 1'b1) begin errors++; $display("FAIL mid_reset_vs: got %b expected 1", vif.VS); end
        if (vif.BLANK !== 1'b0) begin errors++; $display("FAIL mid_reset_blank: got %b expected 0", vif.BLANK); end
        if (vif.RGB !== 24'h0) begin errors++; $display("FAIL mid_reset_rgb: got %h expected 000000", vif.RGB); end
        if (led !== 8'h00) begin errors++; $display("FAIL mid_reset_led: got %h expected 00", led); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        key[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        pos = -1;
        cyc = 0;
        clear_trackers();
        while (pos < VSTART * HTOT + HSTART + 200) step();
        checks += 3;
        if (pix_bad !== 0) begin errors++; $display("FAIL restart_pixels: got %0d bad samples (first at pos %0d) expected 0", pix_bad, first_bad_pos); end
        if (first_hs_fall !== 40) begin errors++; $display("FAIL restart_first_hs: got %0d expected 40", first_hs_fall); end
        if (first_blank !== 13088) begin errors++; $display("FAIL restart_first_blank: got %0d expected 13088", first_blank); end
    endtask

    initial begin
        hif.readdata      = 32'h0;
        hif.readdatavalid = 1'b0;
        hif.waitrequest   = 1'b0;
        test_reset();
        test_leds();
        test_frame_timing();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 3 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
